// File: rtl/uart_stream_arbiter_pkg.sv
// uart_stream_arbiter_pkg: state/grant encodings, ASCII constants and the echo-byte transform.
package uart_stream_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;
  typedef enum logic {GRANT_ECHO, GRANT_MSG} grant_t;
  localparam logic [7:0] CR        = 8'h0D;
  localparam logic [7:0] LF        = 8'h0A;
  localparam logic [7:0] LC_A      = 8'h61;
  localparam logic [7:0] LC_Z      = 8'h7A;
  localparam logic [7:0] CASE_DIFF = 8'h20;
  function automatic logic [7:0] echo_xform(input logic [7:0] b, input logic upcase);
    return (upcase && b >= LC_A && b <= LC_Z) ? b - CASE_DIFF : b;
  endfunction
endpackage

// File: rtl/uart_stream_arbiter_btn.sv
// btn_sync_edge: multi-flop synchroniser for a raw button level followed by a rising-edge detector.
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic din,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end
  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/uart_stream_arbiter.sv
// uart_stream_arbiter: arbitrates FIFO echo bytes and a button-triggered message onto the TX send/ready handshake.
module uart_stream_arbiter
  import uart_stream_arbiter_pkg::*;
#(
  parameter int           MSG_LEN     = 8,
  parameter logic [127:0] MSG         = 128'h0241525459_0D0A03,
  parameter bit           FAIR        = 1'b1,
  parameter int           SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       btn,
  input  logic       cfg_upcase,
  input  logic       cfg_crlf,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rdata,
  output logic       fifo_rd,
  input  logic       tx_ready,
  output logic       tx_send,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       msg_active
);
  localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);
  state_t state_q, state_d;
  grant_t last_grant_q, last_grant_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic [3:0] idx_q, idx_d;
  logic msg_pend_q, msg_pend_d, msg_active_q, msg_active_d, crlf_pend_q, crlf_pend_d;
  logic rise, pick_echo, grant_echo, grant_msg, done, more_msg;

  function automatic logic [7:0] msg_byte(input logic [3:0] i);
    return 8'(MSG >> (8 * (MSG_LEN - 1 - int'(i))));
  endfunction

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_btn (
    .CLK  (CLK),
    .RST_N(RST_N),
    .din  (btn),
    .rise (rise)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_MSG;
      tx_data_q    <= '0;
      idx_q        <= '0;
      msg_pend_q   <= 1'b0;
      msg_active_q <= 1'b0;
      crlf_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      tx_data_q    <= tx_data_d;
      idx_q        <= idx_d;
      msg_pend_q   <= msg_pend_d;
      msg_active_q <= msg_active_d;
      crlf_pend_q  <= crlf_pend_d;
    end
  end

  // On a tie, round-robin hands the grant to whichever source did not win last time.
  always_comb begin
    pick_echo  = !fifo_empty && (!msg_pend_q || !FAIR || last_grant_q == GRANT_MSG);
    grant_echo = state_q == IDLE && tx_ready && pick_echo;
    grant_msg  = state_q == IDLE && tx_ready && msg_pend_q && !pick_echo;
    done       = state_q == WAIT_DONE && tx_ready;
    more_msg   = msg_active_q && idx_q < LAST_IDX;
    state_d    = state_q == IDLE     ? ((grant_echo || grant_msg) ? SEND : IDLE) :
                 state_q == SEND     ? WAIT_ACK :
                 state_q == WAIT_ACK ? (tx_ready ? WAIT_ACK : WAIT_DONE) :
                 !tx_ready ? WAIT_DONE : (more_msg || crlf_pend_q) ? SEND : IDLE;
  end

  always_comb begin
    tx_data_d    = grant_echo          ? echo_xform(fifo_rdata, cfg_upcase) :
                   grant_msg           ? msg_byte(4'd0) :
                   done && more_msg    ? msg_byte(idx_q + 4'd1) :
                   done && crlf_pend_q ? LF : tx_data_q;
    idx_d        = grant_msg ? 4'd0 : (done && more_msg) ? idx_q + 4'd1 : idx_q;
    crlf_pend_d  = grant_echo ? (cfg_crlf && fifo_rdata == CR) : (done && !more_msg) ? 1'b0 : crlf_pend_q;
    msg_active_d = grant_msg ? 1'b1 : (done && !more_msg && !crlf_pend_q) ? 1'b0 : msg_active_q;
    msg_pend_d   = grant_msg ? 1'b0 : (rise && !msg_active_q) ? 1'b1 : msg_pend_q;
    last_grant_d = grant_echo ? GRANT_ECHO : grant_msg ? GRANT_MSG : last_grant_q;
  end

  // The pop strobe is gated by reset so a held reset never consumes a FIFO byte.
  always_comb begin
    fifo_rd    = RST_N && grant_echo;
    tx_send    = state_q == SEND;
    busy       = state_q != IDLE;
    tx_data    = tx_data_q;
    msg_active = msg_active_q;
  end
endmodule

// File: tb/tb_uart_stream_arbiter.sv
// tb_uart_stream_arbiter: scoreboard bench driving a FAIR=1 and a FAIR=0 instance with identical stimulus.
module tb_uart_stream_arbiter;
  logic CLK = 1'b0, RST_N = 1'b0, btn = 1'b0, cfg_upcase = 1'b0, cfg_crlf = 1'b0, hold = 1'b0;
  logic fifo_empty[2], fifo_rd[2], tx_ready[2], tx_send[2], busy[2], msg_active[2];
  logic [7:0] fifo_rdata[2], tx_data[2];
  logic [7:0] fmem[2][16];
  int wp[2], rp[2], cnt[2], send_cnt[2], rd_cnt[2];
  logic [7:0] expq[2][$];
  int tests = 0, fails = 0;
  logic [7:0] msg_b[8] = '{8'h02, 8'h41, 8'h52, 8'h54, 8'h59, 8'h0D, 8'h0A, 8'h03};

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign fifo_empty[g] = wp[g] == rp[g];
    assign fifo_rdata[g] = fmem[g][rp[g] % 16];
    assign tx_ready[g]   = cnt[g] == 0 && !hold;
    uart_stream_arbiter #(.FAIR(g == 0)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .btn       (btn),
      .cfg_upcase(cfg_upcase),
      .cfg_crlf  (cfg_crlf),
      .fifo_empty(fifo_empty[g]),
      .fifo_rdata(fifo_rdata[g]),
      .fifo_rd   (fifo_rd[g]),
      .tx_ready  (tx_ready[g]),
      .tx_send   (tx_send[g]),
      .tx_data   (tx_data[g]),
      .busy      (busy[g]),
      .msg_active(msg_active[g])
    );
  end

  // FIFO pop and TX controller model: ready drops the cycle after a send and returns 4 cycles later.
  always @(posedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (fifo_rd[i]) begin
        rp[i] <= rp[i] + 1;
        rd_cnt[i] <= rd_cnt[i] + 1;
      end
      if (tx_send[i]) send_cnt[i] <= send_cnt[i] + 1;
      cnt[i] <= !RST_N ? 0 : tx_send[i] ? 4 : (cnt[i] > 0 ? cnt[i] - 1 : 0);
    end
  end

  always @(negedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (fifo_rd[i] && fifo_empty[i]) begin
        tests++;
        fails++;
        $display("FAIL rd_while_empty dut%0d got fifo_rd=1 required 0", i);
      end
      if (tx_send[i]) begin
        logic [7:0] e;
        tests++;
        if (expq[i].size() == 0) begin
          fails++;
          $display("FAIL unexpected_send dut%0d got %h required no send", i, tx_data[i]);
        end else begin
          e = expq[i].pop_front();
          if (tx_data[i] !== e) begin
            fails++;
            $display("FAIL tx_data dut%0d got %h required %h", i, tx_data[i], e);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic push(input logic [7:0] b);
    for (int i = 0; i < 2; i++) begin
      fmem[i][wp[i] % 16] = b;
      wp[i]++;
    end
  endtask

  task automatic expect_msg(input int i);
    for (int k = 0; k < 8; k++) expq[i].push_back(msg_b[k]);
  endtask

  task automatic pulse_btn();
    btn = 1'b1;
    step(4);
    btn = 1'b0;
    step(4);
  endtask

  task automatic apply_reset();
    RST_N = 1'b0;
    step(2);
    RST_N = 1'b1;
    step(1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy[0] || busy[1] || !fifo_empty[0] || !fifo_empty[1] ||
            expq[0].size() != 0 || expq[1].size() != 0) && n < 600) begin
      step(1);
      n++;
    end
    tests++;
    if (n >= 600) begin
      fails++;
      $display("FAIL %s_timeout got busy=%0d pending=%0d required idle", name, busy[0], expq[0].size());
    end
  endtask

  task automatic check_zero_outputs(input string name);
    for (int i = 0; i < 2; i++) begin
      tests++;
      if ({fifo_rd[i], tx_send[i], tx_data[i], busy[i], msg_active[i]} !== 12'h000) begin
        fails++;
        $display("FAIL %s dut%0d got rd=%b send=%b data=%h busy=%b act=%b required all 0",
                 name, i, fifo_rd[i], tx_send[i], tx_data[i], busy[i], msg_active[i]);
      end
    end
  endtask

  task automatic test_reset();
    cfg_upcase = 1'b1;
    push(8'h61);
    for (int i = 0; i < 2; i++) expq[i].push_back(8'h41);
    step(2);
    check_zero_outputs("reset");
  endtask

  task automatic test_echo_upcase();
    RST_N = 1'b1;
    #1;
    tests++;
    if (fifo_rd[0] !== 1'b1 || tx_send[0] !== 1'b0) begin
      fails++;
      $display("FAIL echo_rd_t got rd=%b send=%b required rd=1 send=0", fifo_rd[0], tx_send[0]);
    end
    step(1);
    tests++;
    if (tx_send[0] !== 1'b1 || tx_data[0] !== 8'h41 || fifo_rd[0] !== 1'b0) begin
      fails++;
      $display("FAIL echo_send_t1 got send=%b data=%h rd=%b required send=1 data=41 rd=0",
               tx_send[0], tx_data[0], fifo_rd[0]);
    end
    wait_idle("echo");
    tests++;
    if (busy[0] !== 1'b0) begin
      fails++;
      $display("FAIL echo_busy got %b required 0", busy[0]);
    end
  endtask

  task automatic test_crlf_transform();
    int r0 = rd_cnt[0], s0 = send_cnt[0];
    cfg_crlf = 1'b1;
    cfg_upcase = 1'b1;
    push(8'h0D); push(8'h7A); push(8'h60); push(8'h7B);
    for (int i = 0; i < 2; i++) begin
      expq[i].push_back(8'h0D); expq[i].push_back(8'h0A); expq[i].push_back(8'h5A);
      expq[i].push_back(8'h60); expq[i].push_back(8'h7B);
    end
    wait_idle("crlf");
    tests++;
    if (rd_cnt[0] - r0 !== 4 || send_cnt[0] - s0 !== 5) begin
      fails++;
      $display("FAIL crlf_counts got rd=%0d send=%0d required rd=4 send=5", rd_cnt[0] - r0, send_cnt[0] - s0);
    end
  endtask

  task automatic test_message();
    int s0 = send_cnt[0], n = 0;
    for (int i = 0; i < 2; i++) expect_msg(i);
    pulse_btn();
    while (!msg_active[0] && n < 50) begin
      step(1);
      n++;
    end
    tests++;
    if (msg_active[0] !== 1'b1) begin
      fails++;
      $display("FAIL msg_start got msg_active=%b required 1", msg_active[0]);
    end
    step(6);
    pulse_btn();
    wait_idle("msg");
    step(40);
    tests++;
    if (send_cnt[0] - s0 !== 8 || busy[0] !== 1'b0 || msg_active[0] !== 1'b0) begin
      fails++;
      $display("FAIL msg_len got sends=%0d busy=%b act=%b required 8 0 0", send_cnt[0] - s0, busy[0], msg_active[0]);
    end
    cfg_crlf = 1'b0;
    cfg_upcase = 1'b0;
  endtask

  task automatic test_ready_hold();
    int r0, s0;
    hold = 1'b1;
    apply_reset();
    r0 = rd_cnt[0];
    s0 = send_cnt[0];
    push(8'h55);
    for (int i = 0; i < 2; i++) expq[i].push_back(8'h55);
    step(10);
    tests++;
    if (rd_cnt[0] != r0 || send_cnt[0] != s0) begin
      fails++;
      $display("FAIL hold_quiet got rd=%0d send=%0d required 0 0", rd_cnt[0] - r0, send_cnt[0] - s0);
    end
    hold = 1'b0;
    wait_idle("hold");
    tests++;
    if (rd_cnt[0] - r0 !== 1 || send_cnt[0] - s0 !== 1) begin
      fails++;
      $display("FAIL hold_release got rd=%0d send=%0d required 1 1", rd_cnt[0] - r0, send_cnt[0] - s0);
    end
  endtask

  task automatic test_fair();
    int s0, s1;
    hold = 1'b1;
    apply_reset();
    s0 = send_cnt[0];
    s1 = send_cnt[1];
    push(8'h31); push(8'h32); push(8'h33);
    pulse_btn();
    expq[0].push_back(8'h31); expect_msg(0); expq[0].push_back(8'h32); expq[0].push_back(8'h33);
    expq[1].push_back(8'h31); expq[1].push_back(8'h32); expq[1].push_back(8'h33); expect_msg(1);
    hold = 1'b0;
    wait_idle("fair");
    tests++;
    if (send_cnt[0] - s0 !== 11 || send_cnt[1] - s1 !== 11) begin
      fails++;
      $display("FAIL fair_counts got %0d/%0d required 11/11", send_cnt[0] - s0, send_cnt[1] - s1);
    end
  endtask

  task automatic test_reset_mid_msg();
    int s0 = send_cnt[0], n = 0;
    for (int i = 0; i < 2; i++) expect_msg(i);
    pulse_btn();
    while (send_cnt[0] - s0 < 5 && n < 200) begin
      step(1);
      n++;
    end
    step(1);
    tests++;
    if (tx_ready[0] !== 1'b0 || busy[0] !== 1'b1 || tx_data[0] !== 8'h59) begin
      fails++;
      $display("FAIL mid_msg_state got ready=%b busy=%b data=%h required 0 1 59", tx_ready[0], busy[0], tx_data[0]);
    end
    RST_N = 1'b0;
    #1;
    check_zero_outputs("reset_mid");
    for (int i = 0; i < 2; i++) expq[i].delete();
    step(2);
    RST_N = 1'b1;
    s0 = send_cnt[0];
    step(40);
    tests++;
    if (send_cnt[0] != s0 || busy[0] !== 1'b0 || rd_cnt[0] != rd_cnt[1]) begin
      fails++;
      $display("FAIL post_reset_quiet got sends=%0d busy=%b required 0 0", send_cnt[0] - s0, busy[0]);
    end
  endtask

  initial begin
    test_reset();
    test_echo_upcase();
    test_crlf_transform();
    test_message();
    test_ready_hold();
    test_fair();
    test_reset_mid_msg();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
